crossbar_slave_responder: RTL

//   Target-side endpoint for one slave port of main_module_of_Crossbar (dim4).

---
 rtl/crossbar_slave_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/crossbar_slave_responder.sv
// crossbar_slave_responder
// Target-side endpoint for one crossbar slave port. A request is accepted from
// IDLE, held for a programmable number of cycles, then serviced from a local
// word-addressed register file and acknowledged with a four-phase req/ack
// handshake. Requests whose slave-select bits do not match SLAVE_ID return
// MISS_DATA and set a sticky miss flag.
module crossbar_slave_responder #(
  parameter int          ADDR_W    = 4,
  parameter int          LATENCY   = 2,
  parameter logic [1:0]  SLAVE_ID  = 2'b01,
  parameter logic [31:0] MISS_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rreq,
  input  logic [31:0] aaddr,
  input  logic        ccmd,
  input  logic [31:0] wwdata,
  output logic        aack,
  output logic [31:0] rrdata,
  output logic        busy,
  output logic        miss
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              cmd_q, cmd_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              aack_q, aack_d;
  logic [31:0]       rrdata_q, rrdata_d;
  logic              miss_q, miss_d;
  logic              busy_q;

  logic [31:0]       mem_q [DEPTH];
  logic              memWe;

  logic              hit;
  logic              accessNow;

  // Byte-offset bits and the address bits between the word index and the
  // slave-select field carry no meaning for this slave.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{aaddr[29:ADDR_W+2], aaddr[1:0]};

  assign hit       = (sel_q == SLAVE_ID);
  assign accessNow = (state_q == WAIT) && rreq && (cnt_q == 4'd0);

  // State register; reset drops any request in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the four-phase handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rreq) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!rreq) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!rreq) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output next values: request latching, latency countdown,
  // the register-file access itself and the ack/data/miss outputs.
  always_comb begin
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    aack_d   = aack_q;
    rrdata_d = rrdata_q;
    miss_d   = miss_q;
    memWe    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rreq) begin
          sel_d   = aaddr[31:30];
          idx_d   = aaddr[ADDR_W+1:2];
          cmd_d   = ccmd;
          wdata_d = wwdata;
          cnt_d   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end
        if (accessNow) begin
          aack_d = 1'b1;
          if (!hit) begin
            rrdata_d = MISS_DATA;
            miss_d   = 1'b1;
          end else if (cmd_q) begin
            memWe    = 1'b1;
            rrdata_d = wdata_q;
          end else begin
            rrdata_d = mem_q[idx_q];
          end
        end
      end
      ACK: begin
        if (!rreq) begin
          aack_d = 1'b0;
        end
      end
      DONE: begin
        aack_d = 1'b0;
      end
      default: begin
        aack_d = 1'b0;
      end
    endcase
  end

  // Request latches, countdown and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 4'd0;
      sel_q    <= 2'd0;
      idx_q    <= '0;
      cmd_q    <= 1'b0;
      wdata_q  <= 32'd0;
      aack_q   <= 1'b0;
      rrdata_q <= 32'd0;
      miss_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      aack_q   <= aack_d;
      rrdata_q <= rrdata_d;
      miss_q   <= miss_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  // Register file; every word is cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (memWe) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign aack   = aack_q;
  assign rrdata = rrdata_q;
  assign busy   = busy_q;
  assign miss   = miss_q;

endmodule
